// File: rtl/chart_pkg.sv
// chart_pkg: sequencer state encoding, default lane/duration widths and ROM word field offsets for those defaults
package chart_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HOLD, DONE} state_t;
    localparam int TRACKS_DEF = 6;
    localparam int DUR_W_DEF = 8;
    localparam int MASK_LSB = 0;
    localparam int DUR_LSB = TRACKS_DEF;
    localparam int END_BIT = TRACKS_DEF + DUR_W_DEF;
endpackage

// File: rtl/chart_sequencer_tick_gen.sv
// tick_gen: game-clock divider; clk, reset (sync active-low), en counts, clr zeroes (wins over en), tick strobes on the last count
module tick_gen #(
    parameter int TICK_CYCLES = 200000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);
    logic [CW-1:0] cnt;
    assign tick = en && cnt == LAST;
    always_ff @(posedge clk)
        if (!reset || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/chart_sequencer.sv
// chart_sequencer: walks a chart ROM issuing lane spawn pulses; in clk/reset(sync active-low)/start/pause/stop/rom_data, out rom_addr/spawn/tick/busy/done
module chart_sequencer import chart_pkg::*; #(
    parameter int TICK_CYCLES = 200000,
    parameter int ADDR_W = 10,
    parameter int TRACKS = TRACKS_DEF,
    parameter int DUR_W = DUR_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    stop,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [TRACKS+DUR_W:0]   rom_data,
    output logic [TRACKS-1:0]       spawn,
    output logic                    tick,
    output logic                    busy,
    output logic                    done
);
    localparam int DL = DUR_LSB + TRACKS - TRACKS_DEF;
    localparam int EB = END_BIT + TRACKS - TRACKS_DEF + DUR_W - DUR_W_DEF;
    state_t state, state_n;
    logic [ADDR_W-1:0] ptr_n;
    logic [DUR_W-1:0] dur_cnt, dur_n, dur_f;
    logic [TRACKS-1:0] spawn_n;
    logic end_f;
    assign dur_f = rom_data[DL +: DUR_W];
    assign end_f = rom_data[EB];
    assign busy = state == FETCH || state == WAIT || state == ISSUE || state == HOLD;
    assign done = state == DONE;
    // rom_addr doubles as the step pointer; it is stable from FETCH through HOLD
    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state == HOLD && !pause),
        .clr   (state == ISSUE),
        .tick  (tick)
    );
    always_comb begin
        state_n = state;
        ptr_n = rom_addr;
        dur_n = dur_cnt;
        spawn_n = '0;
        case (state)
            IDLE, DONE: if (start) begin
                state_n = FETCH;
                ptr_n = '0;
            end
            FETCH: state_n = WAIT;
            WAIT: state_n = ISSUE;
            ISSUE: if (end_f) state_n = DONE;
            else begin
                state_n = HOLD;
                dur_n = dur_f == '0 ? DUR_W'(1) : dur_f;
                spawn_n = rom_data[MASK_LSB +: TRACKS];
            end
            HOLD: if (tick) begin
                dur_n = dur_cnt - 1'b1;
                // last tick of the step; the top address ends the chart instead of wrapping
                if (dur_cnt == DUR_W'(1)) begin
                    state_n = rom_addr == '1 ? DONE : FETCH;
                    ptr_n = rom_addr == '1 ? rom_addr : rom_addr + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (stop) begin
            state_n = IDLE;
            ptr_n = '0;
            dur_n = '0;
            spawn_n = '0;
        end
    end
    always_ff @(posedge clk)
        if (!reset) begin
            state <= IDLE;
            rom_addr <= '0;
            dur_cnt <= '0;
            spawn <= '0;
        end else begin
            state <= state_n;
            rom_addr <= ptr_n;
            dur_cnt <= dur_n;
            spawn <= spawn_n;
        end
endmodule

// File: tb/tb_chart_sequencer.sv
// tb_chart_sequencer: table, hand-written and model-checked random runs for chart_sequencer at TICK_CYCLES=4
module tb_chart_sequencer;
    localparam int TC = 4;
    localparam int N = 256;
    logic clk = 0, reset = 0, start = 0, pause = 0, stop = 0;
    logic [9:0] addr_a;
    logic [1:0] addr_b;
    logic [14:0] rd_a, rd_b;
    logic [5:0] spawn_a, spawn_b, o_spawn;
    logic tick_a, tick_b, busy_a, busy_b, done_a, done_b, o_tick, o_busy, o_done;
    logic [9:0] o_addr;
    logic [14:0] rom_a [1024];
    logic [14:0] rom_b [4];
    int total = 0, bad = 0;
    bit sel = 0;
    logic [5:0] e_spawn [N];
    bit e_tick [N], e_busy [N], e_done [N], pz [N];
    int e_addr [N];

    always #5 clk = ~clk;
    always @(posedge clk) begin
        rd_a <= rom_a[addr_a];
        rd_b <= rom_b[addr_b];
    end
    assign o_spawn = sel ? spawn_b : spawn_a;
    assign o_tick = sel ? tick_b : tick_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_addr = sel ? {8'b0, addr_b} : addr_a;

    chart_sequencer #(.TICK_CYCLES(TC), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
        .rom_addr(addr_a), .rom_data(rd_a), .spawn(spawn_a), .tick(tick_a), .busy(busy_a), .done(done_a)
    );
    chart_sequencer #(.TICK_CYCLES(TC), .ADDR_W(2)) dut_w (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
        .rom_addr(addr_b), .rom_data(rd_b), .spawn(spawn_b), .tick(tick_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [14:0] wd(input bit e, input int d, input logic [5:0] m);
        return {e, 8'(d), m};
    endfunction

    task automatic check(input string nm, input string f, input int k, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s.%s cyc=%0d got=%0h exp=%0h", nm, f, k, got, exp);
        end
    endtask

    task automatic check_all(input string nm, input int k, input logic [5:0] sp, input bit tk, input bit bz, input bit dn, input int ad);
        check(nm, "spawn", k, 32'(o_spawn), 32'(sp));
        check(nm, "tick", k, 32'(o_tick), 32'(tk));
        check(nm, "busy", k, 32'(o_busy), 32'(bz));
        check(nm, "done", k, 32'(o_done), 32'(dn));
        check(nm, "addr", k, 32'(o_addr), ad);
    endtask

    task automatic step(input logic st, input logic pa, input logic sp, input logic rs);
        @(posedge clk);
        #1;
        start = st;
        pause = pa;
        stop = sp;
        reset = rs;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    function automatic logic [14:0] word(input int a);
        return sel ? rom_b[a % 4] : rom_a[a];
    endfunction

    // Expected per-cycle outputs from the chart rules: 3 cycles fetch/wait/issue, then a hold
    // lasting max(dur,1) ticks where a tick is every TC-th unpaused hold cycle.
    task automatic model(input int s);
        int c, a, d, act, amax;
        logic [14:0] w;
        amax = sel ? 3 : 1023;
        for (int k = 0; k < N; k++) begin
            e_spawn[k] = 0; e_tick[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_addr[k] = 0;
        end
        c = s + 1;
        a = 0;
        while (c < N) begin
            w = word(a);
            for (int k = c; k < N; k++) e_addr[k] = a;
            for (int k = c; k < c + 3 && k < N; k++) e_busy[k] = 1;
            if (w[14]) begin
                for (int k = c + 3; k < N; k++) e_done[k] = 1;
                break;
            end
            c += 3;
            d = (w[13:6] == 0) ? 1 : int'(w[13:6]);
            act = 0;
            if (c < N) e_spawn[c] = w[5:0];
            while (c < N) begin
                e_busy[c] = 1;
                if (!pz[c]) begin
                    act++;
                    if (act % TC == 0) begin
                        e_tick[c] = 1;
                        d--;
                    end
                end
                if (d == 0) break;
                c++;
            end
            if (d != 0) break;
            c++;
            if (a == amax) begin
                for (int k = c; k < N; k++) e_done[k] = 1;
                break;
            end
            a++;
        end
    endtask

    task automatic run_model(input string nm, input int s);
        model(s);
        do_reset();
        for (int k = 0; k < N; k++) begin
            step(k == s, pz[k], 0, 1);
            check_all(nm, k, e_spawn[k], e_tick[k], e_busy[k], e_done[k], e_addr[k]);
        end
    endtask

    task automatic load_basic();
        rom_a[0] = wd(0, 2, 6'b000001);
        rom_a[1] = wd(0, 1, 6'b100010);
        rom_a[2] = wd(1, 0, 6'b000000);
    endtask

    typedef struct {
        logic st, sp;
        logic [5:0] spawn;
        logic tick, busy;
    } vec_t;
    vec_t vec [18];

    initial begin
        for (int i = 0; i < 18; i++) vec[i] = '{0, 0, 6'b0, 0, 1};
        vec[0] = '{1, 0, 6'b0, 0, 0};
        vec[4] = '{0, 0, 6'b000001, 0, 1};
        vec[7] = '{0, 0, 6'b0, 1, 1};
        vec[9] = '{0, 1, 6'b0, 0, 1};
        vec[10] = '{0, 0, 6'b0, 0, 0};
        vec[11] = '{0, 0, 6'b0, 0, 0};
        vec[12] = '{1, 0, 6'b0, 0, 0};
        vec[16] = '{0, 0, 6'b000001, 0, 1};

        load_basic();
        do_reset();
        check_all("reset", 0, 0, 0, 0, 0, 0);

        // stop mid-hold, then restart from address 0
        for (int i = 0; i < 18; i++) begin
            step(vec[i].st, 0, vec[i].sp, 1);
            check_all("stop_tbl", i, vec[i].spawn, vec[i].tick, vec[i].busy, 0, 0);
        end

        for (int k = 0; k < N; k++) pz[k] = 0;
        run_model("basic", 0);
        for (int k = 6; k <= 10; k++) pz[k] = 1;
        run_model("pause", 0);
        for (int k = 0; k < N; k++) pz[k] = 0;
        rom_a[0] = wd(0, 0, 6'b000101);
        run_model("zero_dur", 2);

        // reset during ISSUE must suppress the pending spawn; reset mid-HOLD clears the pointer
        load_basic();
        do_reset();
        for (int k = 0; k < 25; k++) begin
            step(k == 0 || k == 5, 0, 0, !(k == 3 || k == 21));
            if (k == 4 || k == 22) check_all("rst_mid", k, 0, 0, 0, 0, 0);
            if (k == 9) check("rst_mid", "spawn1", k, 32'(o_spawn), 32'h01);
            if (k == 20) check("rst_mid", "spawn2", k, 32'(o_spawn), 32'h22);
            if (k == 21) check("rst_mid", "addr", k, 32'(o_addr), 1);
        end

        // stop and start together: from IDLE, and from DONE
        do_reset();
        step(1, 0, 1, 1);
        for (int k = 1; k < 5; k++) begin
            step(0, 0, 0, 1);
            check_all("ss_idle", k, 0, 0, 0, 0, 0);
        end
        step(1, 0, 0, 1);
        for (int k = 1; k < 23; k++) step(0, 0, 0, 1);
        check("ss_done", "done", 22, 32'(o_done), 1);
        step(1, 0, 1, 1);
        for (int k = 24; k < 29; k++) begin
            step(0, 0, 0, 1);
            check_all("ss_done", k, 0, 0, 0, 0, 0);
        end

        // random charts with random pauses
        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) rom_a[i] = wd(0, $urandom_range(0, 3), 6'($urandom));
            rom_a[len] = wd(1, $urandom_range(0, 3), 6'($urandom));
            for (int k = 0; k < N; k++) pz[k] = ($urandom_range(0, 3) == 0);
            run_model("rand", $urandom_range(0, 3));
        end

        // wrap guard on the 2-bit address instance: no end flag anywhere
        sel = 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) rom_b[i] = wd(0, $urandom_range(0, 2), 6'($urandom));
            for (int k = 0; k < N; k++) pz[k] = (r > 0) && ($urandom_range(0, 4) == 0);
            run_model("wrap", r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
